// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Purpose  : Pipeline execute stage. It holds the ALU, the branch-target adder
//            and the EX/MEM register. Define EX_STAGE_MUL_EN to add a
//            64-cycle shift-add MUL unit that stalls the upstream pipe.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        flush,
    input  logic [63:0] rs1_data,
    input  logic [63:0] rs2_data,
    input  logic [63:0] imm,
    input  logic [7:0]  pc_in,
    input  logic [31:0] instruction,
    input  logic [4:0]  rd,
    input  logic        MemtoReg,
    input  logic        regwrite,
    input  logic        branch,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        alu_src,
    input  logic [1:0]  alu_op,
    output logic [63:0] alu_result,
    output logic [63:0] rs2_data_out,
    output logic        zero,
    output logic [7:0]  branch_target,
    output logic [4:0]  rd_out,
    output logic        MemtoReg_out,
    output logic        regwrite_out,
    output logic        branch_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        out_valid,
    output logic        stall
);

    localparam logic [6:0] c_OP_RTYPE = 7'b0110011;

    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [6:0]  w_opcode;
    logic [63:0] w_op2;
    logic [63:0] w_alu;
    logic [5:0]  w_shamt;
    logic        w_accept;
    logic        w_is_mul;
    logic        w_unused;

    assign w_funct3 = instruction[14:12];
    assign w_funct7 = instruction[31:25];
    assign w_opcode = instruction[6:0];
    assign w_op2    = alu_src ? imm : rs2_data;
    assign w_shamt  = w_op2[5:0];
    assign w_accept = in_valid && !flush && !stall;
    assign w_unused = ^instruction;

    always_comb begin
        w_alu = rs1_data + w_op2;
        case (alu_op)
            2'b01: w_alu = rs1_data - w_op2;
            2'b10: begin
                case (w_funct3)
                    3'b000: if (w_opcode == c_OP_RTYPE && w_funct7[5]) w_alu = rs1_data - w_op2;
                    3'b111: w_alu = rs1_data & w_op2;
                    3'b110: w_alu = rs1_data | w_op2;
                    3'b100: w_alu = rs1_data ^ w_op2;
                    3'b001: w_alu = rs1_data << w_shamt;
                    3'b101: w_alu = w_funct7[5] ? 64'($signed(rs1_data) >>> w_shamt)
                                                : (rs1_data >> w_shamt);
                    3'b010: w_alu = {63'd0, $signed(rs1_data) < $signed(w_op2)};
                    default: w_alu = rs1_data + w_op2;
                endcase
            end
            default: w_alu = rs1_data + w_op2;
        endcase
    end

`ifdef EX_STAGE_MUL_EN
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_cnt;
    logic [63:0] r_mcand;
    logic [63:0] r_mplier;
    logic [63:0] r_acc;
    logic [4:0]  r_mul_rd;
    logic [4:0]  r_mul_ctl;
    logic [63:0] w_acc_nxt;
    logic        w_mul_done;

    assign w_is_mul   = (alu_op == 2'b10) && (w_opcode == c_OP_RTYPE) &&
                        (w_funct7 == 7'b0000001) && (w_funct3 == 3'b000);
    assign w_mul_done = (r_state == S_MUL) && (r_cnt == 6'd63);
    assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : 64'd0);
    assign stall      = (r_state == S_MUL);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
            S_MUL:   if (w_mul_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Unsigned shift-add keeps the low 64 bits of the signed product exact.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 6'd0;
            r_mcand   <= 64'd0;
            r_mplier  <= 64'd0;
            r_acc     <= 64'd0;
            r_mul_rd  <= 5'd0;
            r_mul_ctl <= 5'd0;
        end else if (w_accept && w_is_mul) begin
            r_cnt     <= 6'd0;
            r_mcand   <= rs1_data;
            r_mplier  <= rs2_data;
            r_acc     <= 64'd0;
            r_mul_rd  <= rd;
            r_mul_ctl <= {MemtoReg, regwrite, branch, MemRead, MemWrite};
        end else if (r_state == S_MUL) begin
            r_cnt     <= r_cnt + 6'd1;
            r_mcand   <= r_mcand << 1;
            r_mplier  <= r_mplier >> 1;
            r_acc     <= w_acc_nxt;
        end
    end
`else
    assign w_is_mul = 1'b0;
    assign stall    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result    <= 64'd0;
            rs2_data_out  <= 64'd0;
            zero          <= 1'b0;
            branch_target <= 8'd0;
            rd_out        <= 5'd0;
            MemtoReg_out  <= 1'b0;
            regwrite_out  <= 1'b0;
            branch_out    <= 1'b0;
            MemRead_out   <= 1'b0;
            MemWrite_out  <= 1'b0;
            out_valid     <= 1'b0;
        end else begin
            // Bubble by default; data fields hold unless something retires.
            out_valid    <= 1'b0;
            regwrite_out <= 1'b0;
            branch_out   <= 1'b0;
            MemRead_out  <= 1'b0;
            MemWrite_out <= 1'b0;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (w_accept && !w_is_mul) begin
                alu_result    <= w_alu;
                rs2_data_out  <= rs2_data;
                zero          <= (w_alu == 64'd0);
                branch_target <= pc_in + imm[7:0];
                rd_out        <= rd;
                MemtoReg_out  <= MemtoReg;
                regwrite_out  <= regwrite;
                branch_out    <= branch;
                MemRead_out   <= MemRead;
                MemWrite_out  <= MemWrite;
                out_valid     <= 1'b1;
            end
`ifdef EX_STAGE_MUL_EN
            else if (w_mul_done) begin
                alu_result   <= w_acc_nxt;
                zero         <= (w_acc_nxt == 64'd0);
                rd_out       <= r_mul_rd;
                MemtoReg_out <= r_mul_ctl[4];
                regwrite_out <= r_mul_ctl[3];
                branch_out   <= r_mul_ctl[2];
                MemRead_out  <= r_mul_ctl[1];
                MemWrite_out <= r_mul_ctl[0];
                out_valid    <= 1'b1;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// Directed self-checking bench for ex_stage; MUL scenarios run only when
// EX_STAGE_MUL_EN is defined.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush;
    logic [63:0] rs1_data, rs2_data, imm;
    logic [7:0]  pc_in;
    logic [31:0] instruction;
    logic [4:0]  rd;
    logic        MemtoReg, regwrite, branch, MemRead, MemWrite, alu_src;
    logic [1:0]  alu_op;
    logic [63:0] alu_result, rs2_data_out;
    logic        zero;
    logic [7:0]  branch_target;
    logic [4:0]  rd_out;
    logic        MemtoReg_out, regwrite_out, branch_out, MemRead_out, MemWrite_out;
    logic        out_valid, stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc_in(pc_in),
        .instruction(instruction), .rd(rd), .MemtoReg(MemtoReg),
        .regwrite(regwrite), .branch(branch), .MemRead(MemRead),
        .MemWrite(MemWrite), .alu_src(alu_src), .alu_op(alu_op),
        .alu_result(alu_result), .rs2_data_out(rs2_data_out), .zero(zero),
        .branch_target(branch_target), .rd_out(rd_out),
        .MemtoReg_out(MemtoReg_out), .regwrite_out(regwrite_out),
        .branch_out(branch_out), .MemRead_out(MemRead_out),
        .MemWrite_out(MemWrite_out), .out_valid(out_valid), .stall(stall)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
        return {f7, 10'd0, f3, 5'd0, op};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_alu"},   alu_result, 64'd0);
        check({tag, "_rs2"},   rs2_data_out, 64'd0);
        check({tag, "_zero"},  {63'd0, zero}, 64'd0);
        check({tag, "_bt"},    {56'd0, branch_target}, 64'd0);
        check({tag, "_rd"},    {59'd0, rd_out}, 64'd0);
        check({tag, "_ctl"},   {59'd0, MemtoReg_out, regwrite_out, branch_out, MemRead_out, MemWrite_out}, 64'd0);
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_stall"}, {63'd0, stall}, 64'd0);
    endtask

    initial begin
        logic ok;
        rst = 1; flush = 0; in_valid = 1;
        rs1_data = 64'd5; rs2_data = -64'sd7; imm = 64'd100; pc_in = 8'd16;
        instruction = mk(7'd0, 3'b000, 7'b0110011); rd = 5'd3;
        MemtoReg = 1; regwrite = 1; branch = 1; MemRead = 1; MemWrite = 1;
        alu_src = 0; alu_op = 2'b10;

        tick(); tick();
        check_all_zero("reset");

        // R-type ADD
        rst = 0; MemtoReg = 0; branch = 0; MemRead = 0; MemWrite = 0;
        tick();
        check("add_result", alu_result, -64'sd2);
        check("add_zero", {63'd0, zero}, 64'd0);
        check("add_valid", {63'd0, out_valid}, 64'd1);
        check("add_regwrite", {63'd0, regwrite_out}, 64'd1);
        check("add_rd", {59'd0, rd_out}, 64'd3);
        check("add_rs2out", rs2_data_out, -64'sd7);
        check("add_bt", {56'd0, branch_target}, 64'd116);

        // R-type SUB, then I-type with funct7[5]=1 must still ADD
        instruction = mk(7'b0100000, 3'b000, 7'b0110011);
        tick();
        check("sub_result", alu_result, 64'd12);
        instruction = mk(7'b0100000, 3'b000, 7'b0010011); alu_src = 1; imm = 64'd10;
        tick();
        check("itype_add", alu_result, 64'd15);

        // Branch compare with target wrap
        alu_op = 2'b01; alu_src = 0; branch = 1; regwrite = 0;
        rs1_data = 64'd42; rs2_data = 64'd42; pc_in = 8'd250; imm = 64'd10;
        tick();
        check("br_zero", {63'd0, zero}, 64'd1);
        check("br_branch_out", {63'd0, branch_out}, 64'd1);
        check("br_target", {56'd0, branch_target}, 64'd4);
        check("br_regwrite", {63'd0, regwrite_out}, 64'd0);

        // Logic ops
        branch = 0; regwrite = 1; alu_op = 2'b10;
        rs1_data = 64'hF0F0; rs2_data = 64'hFF00;
        instruction = mk(7'd0, 3'b111, 7'b0110011); tick();
        check("and", alu_result, 64'hF000);
        instruction = mk(7'd0, 3'b110, 7'b0110011); tick();
        check("or", alu_result, 64'hFFF0);
        instruction = mk(7'd0, 3'b100, 7'b0110011); tick();
        check("xor", alu_result, 64'h0FF0);

        // Shifts: amount uses only operand2[5:0] (70 -> 6)
        rs1_data = 64'd1; imm = 64'd70; alu_src = 1;
        instruction = mk(7'd0, 3'b001, 7'b0010011); tick();
        check("sll", alu_result, 64'd64);
        alu_src = 0; rs1_data = -64'sd16; rs2_data = 64'd2;
        instruction = mk(7'b0100000, 3'b101, 7'b0110011); tick();
        check("sra", alu_result, -64'sd4);
        instruction = mk(7'd0, 3'b101, 7'b0110011); tick();
        check("srl", alu_result, 64'h3FFF_FFFF_FFFF_FFFC);

        // SLT signed
        rs1_data = -64'sd1; rs2_data = 64'd1;
        instruction = mk(7'd0, 3'b010, 7'b0110011); tick();
        check("slt_true", alu_result, 64'd1);
        rs1_data = 64'd1; rs2_data = -64'sd1; tick();
        check("slt_false", alu_result, 64'd0);
        check("slt_zero", {63'd0, zero}, 64'd1);

        // alu_op 11 and 00 ignore funct3; overflow wraps
        alu_op = 2'b11; rs1_data = 64'd3; rs2_data = 64'd4;
        instruction = mk(7'd0, 3'b111, 7'b0110011); tick();
        check("op11_add", alu_result, 64'd7);
        alu_op = 2'b00; rs1_data = 64'h7FFF_FFFF_FFFF_FFFF; rs2_data = 64'd1; tick();
        check("op00_ovf", alu_result, 64'h8000_0000_0000_0000);

        // Load-style control bits
        alu_src = 1; imm = 64'd8; rs1_data = 64'd100; pc_in = 8'd0;
        MemRead = 1; MemtoReg = 1; regwrite = 1; rd = 5'd7; tick();
        check("load_addr", alu_result, 64'd108);
        check("load_ctl", {59'd0, MemtoReg_out, regwrite_out, branch_out, MemRead_out, MemWrite_out}, 64'b11010);

        // Bubble: data fields hold, enables drop
        in_valid = 0; rs1_data = 64'd999; rd = 5'd1; tick();
        check("bub_valid", {63'd0, out_valid}, 64'd0);
        check("bub_regwrite", {63'd0, regwrite_out}, 64'd0);
        check("bub_memread", {63'd0, MemRead_out}, 64'd0);
        check("bub_alu_hold", alu_result, 64'd108);
        check("bub_rd_hold", {59'd0, rd_out}, 64'd7);
        check("bub_m2r_hold", {63'd0, MemtoReg_out}, 64'd1);

        // Store then flush with in_valid
        in_valid = 1; MemRead = 0; MemtoReg = 0; regwrite = 0; MemWrite = 1;
        rs2_data = 64'hABCD; rs1_data = 64'd200; tick();
        check("store_we", {63'd0, MemWrite_out}, 64'd1);
        check("store_data", rs2_data_out, 64'hABCD);
        flush = 1; regwrite = 1; rs1_data = 64'd5; tick();
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        check("flush_we", {62'd0, regwrite_out, MemWrite_out}, 64'd0);
        check("flush_alu_hold", alu_result, 64'd208);
        flush = 0; MemWrite = 0;

        // funct7=0000001 funct3=000 R-type
        alu_op = 2'b10; alu_src = 0; rd = 5'd9;
        rs1_data = -64'sd3; rs2_data = 64'd1000000007;
        instruction = mk(7'b0000001, 3'b000, 7'b0110011);
`ifndef EX_STAGE_MUL_EN
        tick();
        check("m_as_add", alu_result, 64'd1000000004);
        check("m_as_add_stall", {63'd0, stall}, 64'd0);
`else
        tick();
        check("mul_e0_stall", {63'd0, stall}, 64'd1);
        check("mul_e0_valid", {63'd0, out_valid}, 64'd0);
        // Hold a new ADD through the stall
        rs1_data = 64'd7; rs2_data = 64'd8; rd = 5'd4;
        instruction = mk(7'd0, 3'b000, 7'b0110011);
        ok = 1;
        for (int i = 1; i < 64; i++) begin
            tick();
            if (stall !== 1'b1 || out_valid !== 1'b0) ok = 0;
        end
        check("mul_stall_window", {63'd0, ok}, 64'd1);
        tick();
        check("mul_e64_stall", {63'd0, stall}, 64'd0);
        check("mul_e64_valid", {63'd0, out_valid}, 64'd1);
        check("mul_result", alu_result, -64'sd3000000021);
        check("mul_rd", {59'd0, rd_out}, 64'd9);
        tick();
        check("post_mul_add", alu_result, 64'd15);
        check("post_mul_rd", {59'd0, rd_out}, 64'd4);
        check("post_mul_valid", {63'd0, out_valid}, 64'd1);

        // Abort by flush at iteration 20
        rs1_data = 64'd6; rs2_data = 64'd6; rd = 5'd2;
        instruction = mk(7'b0000001, 3'b000, 7'b0110011); tick();
        in_valid = 0;
        for (int i = 1; i < 20; i++) tick();
        flush = 1; tick();
        check("abort_stall", {63'd0, stall}, 64'd0);
        check("abort_valid", {63'd0, out_valid}, 64'd0);
        flush = 0; in_valid = 1; rs1_data = 64'd1; rs2_data = 64'd2;
        instruction = mk(7'd0, 3'b000, 7'b0110011); tick();
        check("abort_add", alu_result, 64'd3);
        check("abort_add_valid", {63'd0, out_valid}, 64'd1);

        // Abort by reset at iteration 20
        instruction = mk(7'b0000001, 3'b000, 7'b0110011); tick();
        in_valid = 0;
        for (int i = 1; i < 20; i++) tick();
        rst = 1; in_valid = 1; tick();
        check_all_zero("rst_abort");
        rst = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 The block SHALL have these inputs, all driven from the ID/EX register:
- in_valid  in  1  ID/EX holds a real instruction
- flush  in  1  squash the instruction being accepted and abort any multiply
- rs1_data, rs2_data, imm  in  64 each  signed operands
- pc_in  in  8  byte PC of the instruction
- instruction  in  32  raw instruction; funct3 = [14:12], funct7 = [31:25], opcode = [6:0]
- rd  in  5  destination register
- MemtoReg, regwrite, branch, MemRead, MemWrite, alu_src  in  1 each  control bits
- alu_op  in  2  ALU class
REQ-003 The block SHALL have these outputs, all forming the EX/MEM register:
- alu_result  out  64  ALU result
- rs2_data_out  out  64  store data
- zero  out  1  alu_result == 0
- branch_target  out  8  computed branch target
- rd_out  out  5  destination register
- MemtoReg_out, regwrite_out, branch_out, MemRead_out, MemWrite_out  out  1 each  control bits
- out_valid  out  1  EX/MEM holds a real instruction
- stall  out  1  block busy; upstream SHALL hold PC, IF/ID and ID/EX

Function
REQ-004 The second operand SHALL be imm when alu_src=1, else rs2_data.
REQ-005 ALU operation SHALL be selected as follows:
- alu_op=00: ADD
- alu_op=01: SUB
- alu_op=10: decoded from funct3/funct7:
  - 000: ADD, or SUB only when opcode=0110011 and funct7[5]=1
  - 111: AND; 110: OR; 100: XOR
  - 001: SLL; 101: SRL/SRA by funct7[5]; shift amount = operand2[5:0]
  - 010: SLT (signed)
- alu_op=11: ADD
REQ-006 All arithmetic SHALL be 64-bit two's complement with overflow discarded.
REQ-007 branch_target SHALL be (pc_in + imm[7:0]) modulo 256; wrap-around SHALL NOT be flagged.
REQ-008 An instruction SHALL be accepted on a rising edge where in_valid=1, stall=0 and flush=0.
REQ-009 For a single-cycle op, all outputs SHALL be registered at the accepting edge, with out_valid=1 in the following cycle (latency 1).
REQ-010 On an edge with no acceptance (in_valid=0, or flush=1) and state IDLE:
- out_valid, regwrite_out, MemRead_out, MemWrite_out and branch_out SHALL be 0 (bubble)
- alu_result, rs2_data_out, zero, branch_target, rd_out and MemtoReg_out SHALL hold their previous values.
REQ-011 The FSM SHALL have two states, IDLE and MUL; stall SHALL equal (state==MUL), driven directly from the state register.
REQ-012 While in MUL, in_valid SHALL be ignored, and outputs SHALL show a bubble as in REQ-010.
REQ-013 When flush=1 at any edge, out_valid and all write-enable/branch outputs SHALL be cleared; a MUL in progress SHALL be abandoned, with the state returning to IDLE.
REQ-014 flush SHALL take priority over in_valid on the same edge.

Reset
REQ-015 When rst=1 at a rising edge, all outputs SHALL become 0, the state SHALL become IDLE and the iteration counter SHALL become 0.
REQ-016 rst SHALL take priority over flush and in_valid, including mid-multiply.

Configuration
REQ-017 When macro EX_STAGE_MUL_EN is defined, an accepted instruction with alu_op=10, opcode=0110011, funct7=0000001 and funct3=000 SHALL perform MUL (low 64 bits of rs1_data*rs2_data):
- at the accepting edge (E0), the FSM SHALL enter MUL and latch the operands
- one shift-add iteration SHALL run per edge, on E1..E64
- at E64 the result, rd and control bits SHALL be registered with out_valid=1, and the FSM SHALL return to IDLE
- stall SHALL be 1 from after E0 until after E64 (64 cycles)
REQ-018 When EX_STAGE_MUL_EN is undefined:
- no MUL state, counter or multiplier datapath SHALL exist
- stall SHALL be tied to 0
- funct7=0000001 instructions SHALL execute as the funct3-selected op with funct7[5]=0.

Verification
REQ-019 Reset: hold rst=1 for 2 cycles with in_valid=1 -> every output reads 0, stall=0.
REQ-020 ADD: alu_op=10, opcode=0110011, funct3=000, funct7=0, rs1=5, rs2=-7 -> next cycle alu_result=-2, zero=0, out_valid=1.
REQ-021 Branch: alu_op=01, branch=1, rs1=rs2=42, pc_in=250, imm=10 -> next cycle zero=1, branch_out=1, branch_target=4 (wrap-around).
REQ-022 Bubble and flush:
- in_valid=0 -> next cycle out_valid=0, regwrite_out=0, alu_result unchanged
- flush=1 together with in_valid=1 -> next cycle out_valid=0.
REQ-023 MUL (EX_STAGE_MUL_EN defined): rs1=-3, rs2=1000000007 -> stall=1 for exactly 64 cycles, then alu_result=-3000000021 with out_valid=1 for one cycle; a new in_valid held during the stall is accepted only on the edge after stall falls.
REQ-024 MUL abort: flush=1 at iteration 20 -> stall=0 and out_valid=0 the next cycle; a following ADD completes with latency 1. Repeating with rst=1 instead of flush -> all outputs 0.
